load_queue: RTL and testbench
=============================

# load_queue

Circular load queue for the out-of-order core, built from an array of load-buffer entries of `LDQ_BUF_SIZE` slots. Each load is allocated in program order at dispatch and receives its address from the AGU. It issues to memory once every older store has committed, then broadcasts its result on the CDB with its ROB tag. The queue frees the head entry when the ROB commits it. It sits between dispatch/AGU and the data-memory port, alongside the store queue.

## Interface
- `XLEN`, 32, data/address width
- `LDQ_BUF_SIZE`, 8, load queue entries (power of two)
- `STQ_BUF_SIZE`, 8, store queue entries (width of store_mask)
- `ROB_TAG_WIDTH`, 5, ROB tag width

- `clk` in 1, clock; the only clock
- `reset_n` in 1, synchronous active-low reset, sampled on the rising edge of `clk`
- `alloc_valid` in 1, allocate a load at tail
- `alloc_rob_tag` in ROB_TAG_WIDTH, ROB tag of allocated load
- `alloc_store_mask` in STQ_BUF_SIZE, older uncommitted stores at dispatch
- `alloc_ready` out 1, queue not full
- `alloc_index` out clog2(LDQ_BUF_SIZE), current tail index
- `addr_valid` in 1, AGU address write
- `addr_index` in clog2(LDQ_BUF_SIZE), target entry
- `addr` in XLEN, computed address
- `store_commit_valid` in 1, a store retired from the store queue
- `store_commit_index` in clog2(STQ_BUF_SIZE), its store queue index
- `mem_req_valid` out 1, load request to memory
- `mem_req_addr` out XLEN, request address
- `mem_req_index` out clog2(LDQ_BUF_SIZE), issuing entry
- `mem_req_ready` in 1, memory accepts request
- `mem_resp_valid` in 1, load data returned
- `mem_resp_index` in clog2(LDQ_BUF_SIZE), entry being answered
- `mem_resp_data` in XLEN, load data
- `cdb_valid` out 1, result broadcast
- `cdb_rob_tag` out ROB_TAG_WIDTH, broadcast tag
- `cdb_data` out XLEN, broadcast data
- `commit_valid` in 1, ROB retires the oldest load
- `flush` in 1, discard all entries
- `full` out 1, `empty` out 1, occupancy flags

## Operation
- **Per-entry state:** valid, address, address_valid, executed, succeeded, store_mask, rob_tag.
- **Pointers:** head and tail are clog2(LDQ_BUF_SIZE)-bit and wrap modulo LDQ_BUF_SIZE. Count is clog2(LDQ_BUF_SIZE)+1 bits. `full` = count==LDQ_BUF_SIZE; `empty` = count==0; `alloc_ready` = !full.
- **Allocate** (alloc_valid && alloc_ready):
  - entry[tail] gets valid=1, rob_tag, store_mask = alloc_store_mask with the same-cycle store_commit bit cleared, and all other flags 0.
  - tail increments.
  - alloc_valid while full is ignored.
- **Address write:** sets address and address_valid. Ignored if entry[addr_index] is not valid.
- **Store commit:** clears bit store_commit_index in every entry's store_mask.
- **Issue select:**
  - An entry is ready when valid && address_valid && !executed && store_mask==0.
  - The oldest ready entry, searching from head with wrap, drives mem_req_*.
  - mem_req_valid && mem_req_ready sets executed on that entry.
  - There is no store-to-load forwarding.
- **Response:** stores mem_resp_data and sets succeeded on entry[mem_resp_index]. Responses for invalid entries are dropped.
- **Commit:** commit_valid frees head only if head is valid && succeeded; otherwise it is ignored. On free, head increments.
- **Flush:** all valid=0, head=tail, count=0. A CDB broadcast already registered still goes out. Flush has priority over alloc, address write, response and commit in the same cycle.
- **Simultaneous alloc + commit:** count unchanged. alloc_ready is based on the pre-edge count.

## Timing
- All state updates occur on the rising edge of clk.
- mem_req_* is combinational from registered state. An address written at edge t can issue in the cycle after t.
- A store commit at edge t makes the load eligible in the cycle after t.
- mem_resp at cycle t gives cdb_valid/cdb_rob_tag/cdb_data registered in cycle t+1, held for one cycle. There is no CDB backpressure.
- **Reset** (reset_n low at an edge): all entries invalid, head=tail=count=0. Output values after reset:
  - alloc_ready=1, alloc_index=0
  - empty=1, full=0
  - mem_req_valid=0, mem_req_addr=0, mem_req_index=0
  - cdb_valid=0, cdb_rob_tag=0, cdb_data=0
- Reset mid-operation discards in-flight responses.

## Test plan
- **Basic load:** alloc tag 3, mask 0; addr 0x100 → mem_req_valid with addr 0x100, index 0. Resp data 0xDEAD → next cycle cdb_valid, tag 3, data 0xDEAD. commit → empty=1.
- **Store dependency:** alloc with mask 0b0100, addr written → no mem_req. store_commit_index=2 → mem_req_valid the following cycle.
- **Oldest-first issue:** entries 0 and 1 both become ready in the same cycle → index 0 issues first. With mem_req_ready=0 for 3 cycles, the request holds stable at index 0.
- **Full and wrap:** 8 allocs → full=1, alloc_ready=0, and a 9th alloc is ignored. Alloc + commit in the same cycle when count=7 → count stays 7, tail wraps to 0.
- **Flush:** flush during pending requests → empty=1 and mem_req_valid=0 next cycle. A late resp to index 1 is dropped with no cdb_valid.
- **Commit guard:** commit_valid while head is not succeeded → head unchanged.

Source files
------------

// File: rtl/load_queue.sv
// Circular load queue: loads are allocated in program order, wait for their
// address and for older stores to commit, issue oldest-first to memory, then
// broadcast their result on the CDB. The ROB frees the head entry in order.
module load_queue #(
    parameter int XLEN          = 32,
    parameter int LDQ_BUF_SIZE  = 8,
    parameter int STQ_BUF_SIZE  = 8,
    parameter int ROB_TAG_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              alloc_valid,
    input  logic [ROB_TAG_WIDTH-1:0]          alloc_rob_tag,
    input  logic [STQ_BUF_SIZE-1:0]           alloc_store_mask,
    output logic                              alloc_ready,
    output logic [$clog2(LDQ_BUF_SIZE)-1:0]   alloc_index,
    input  logic                              addr_valid,
    input  logic [$clog2(LDQ_BUF_SIZE)-1:0]   addr_index,
    input  logic [XLEN-1:0]                   addr,
    input  logic                              store_commit_valid,
    input  logic [$clog2(STQ_BUF_SIZE)-1:0]   store_commit_index,
    output logic                              mem_req_valid,
    output logic [XLEN-1:0]                   mem_req_addr,
    output logic [$clog2(LDQ_BUF_SIZE)-1:0]   mem_req_index,
    input  logic                              mem_req_ready,
    input  logic                              mem_resp_valid,
    input  logic [$clog2(LDQ_BUF_SIZE)-1:0]   mem_resp_index,
    input  logic [XLEN-1:0]                   mem_resp_data,
    output logic                              cdb_valid,
    output logic [ROB_TAG_WIDTH-1:0]          cdb_rob_tag,
    output logic [XLEN-1:0]                   cdb_data,
    input  logic                              commit_valid,
    input  logic                              flush,
    output logic                              full,
    output logic                              empty
);

    localparam int IDX_W = $clog2(LDQ_BUF_SIZE);
    localparam int CNT_W = IDX_W + 1;

    // Per-entry state, flag vectors packed for cheap reductions
    logic [LDQ_BUF_SIZE-1:0]  valid_q, valid_d;
    logic [LDQ_BUF_SIZE-1:0]  addr_valid_q, addr_valid_d;
    logic [LDQ_BUF_SIZE-1:0]  executed_q, executed_d;
    logic [LDQ_BUF_SIZE-1:0]  succeeded_q, succeeded_d;
    logic [XLEN-1:0]          addr_q [LDQ_BUF_SIZE];
    logic [XLEN-1:0]          addr_d [LDQ_BUF_SIZE];
    logic [STQ_BUF_SIZE-1:0]  store_mask_q [LDQ_BUF_SIZE];
    logic [STQ_BUF_SIZE-1:0]  store_mask_d [LDQ_BUF_SIZE];
    logic [ROB_TAG_WIDTH-1:0] rob_tag_q [LDQ_BUF_SIZE];
    logic [ROB_TAG_WIDTH-1:0] rob_tag_d [LDQ_BUF_SIZE];

    // Queue pointers and occupancy
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered CDB broadcast
    logic                     cdb_valid_q, cdb_valid_d;
    logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag_q, cdb_rob_tag_d;
    logic [XLEN-1:0]          cdb_data_q, cdb_data_d;

    // Issue select
    logic [LDQ_BUF_SIZE-1:0] ready_vec;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_index;
    logic [IDX_W-1:0]        scan_idx;

    // Event qualifiers
    logic                    alloc_fire;
    logic                    commit_fire;
    logic                    issue_fire;
    logic                    resp_hit;
    logic                    addr_hit;
    logic [STQ_BUF_SIZE-1:0] store_clear_mask;

    assign full        = (count_q == CNT_W'(LDQ_BUF_SIZE));
    assign empty       = (count_q == '0);
    assign alloc_ready = !full;
    assign alloc_index = tail_q;

    // Flush dominates every other same-cycle update
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign commit_fire = commit_valid && valid_q[head_q] && succeeded_q[head_q] && !flush;
    assign issue_fire  = sel_found && mem_req_ready && !flush;
    assign resp_hit    = mem_resp_valid && valid_q[mem_resp_index] && !flush;
    assign addr_hit    = addr_valid && valid_q[addr_index] && !flush;

    assign store_clear_mask = store_commit_valid
                            ? ({{(STQ_BUF_SIZE-1){1'b0}}, 1'b1} << store_commit_index)
                            : '0;

    // Oldest ready entry, scanning from head with wrap-around
    always_comb begin
        ready_vec = '0;
        sel_found = 1'b0;
        sel_index = '0;
        scan_idx  = '0;
        for (int i = 0; i < LDQ_BUF_SIZE; i++) begin
            ready_vec[i] = valid_q[i] && addr_valid_q[i] && !executed_q[i]
                        && (store_mask_q[i] == '0);
        end
        for (int i = 0; i < LDQ_BUF_SIZE; i++) begin
            scan_idx = head_q + IDX_W'(i);
            if (!sel_found && ready_vec[scan_idx]) begin
                sel_found = 1'b1;
                sel_index = scan_idx;
            end
        end
    end

    assign mem_req_valid = sel_found;
    assign mem_req_index = sel_index;
    assign mem_req_addr  = sel_found ? addr_q[sel_index] : '0;

    // Next-state for entries, pointers, count and CDB register
    always_comb begin
        valid_d       = valid_q;
        addr_valid_d  = addr_valid_q;
        executed_d    = executed_q;
        succeeded_d   = succeeded_q;
        addr_d        = addr_q;
        rob_tag_d     = rob_tag_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        cdb_valid_d   = resp_hit;
        cdb_rob_tag_d = cdb_rob_tag_q;
        cdb_data_d    = cdb_data_q;

        // A committing store releases its dependency in every entry
        for (int i = 0; i < LDQ_BUF_SIZE; i++) begin
            store_mask_d[i] = store_mask_q[i] & ~store_clear_mask;
        end

        if (alloc_fire) begin
            valid_d[tail_q]      = 1'b1;
            addr_valid_d[tail_q] = 1'b0;
            executed_d[tail_q]   = 1'b0;
            succeeded_d[tail_q]  = 1'b0;
            addr_d[tail_q]       = '0;
            rob_tag_d[tail_q]    = alloc_rob_tag;
            store_mask_d[tail_q] = alloc_store_mask & ~store_clear_mask;
            tail_d               = tail_q + 1'b1;
        end

        if (addr_hit) begin
            addr_d[addr_index]       = addr;
            addr_valid_d[addr_index] = 1'b1;
        end

        if (issue_fire) begin
            executed_d[sel_index] = 1'b1;
        end

        if (resp_hit) begin
            succeeded_d[mem_resp_index] = 1'b1;
            cdb_rob_tag_d               = rob_tag_q[mem_resp_index];
            cdb_data_d                  = mem_resp_data;
        end

        if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        if (alloc_fire && !commit_fire) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_fire && commit_fire) begin
            count_d = count_q - 1'b1;
        end

        // Already-registered CDB output is left alone so it still goes out
        if (flush) begin
            valid_d = '0;
            head_d  = tail_q;
            count_d = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q       <= '0;
            addr_valid_q  <= '0;
            executed_q    <= '0;
            succeeded_q   <= '0;
            for (int i = 0; i < LDQ_BUF_SIZE; i++) begin
                addr_q[i]       <= '0;
                store_mask_q[i] <= '0;
                rob_tag_q[i]    <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_rob_tag_q <= '0;
            cdb_data_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            addr_valid_q  <= addr_valid_d;
            executed_q    <= executed_d;
            succeeded_q   <= succeeded_d;
            addr_q        <= addr_d;
            store_mask_q  <= store_mask_d;
            rob_tag_q     <= rob_tag_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_tag_q <= cdb_rob_tag_d;
            cdb_data_q    <= cdb_data_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_tag = cdb_rob_tag_q;
    assign cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_load_queue.sv
// Self-checking bench for load_queue: scenario tasks with inline checks,
// plus a CDB scoreboard fed when responses are driven.
module tb_load_queue;

    localparam int XLEN = 32;
    localparam int LDQ  = 8;
    localparam int STQ  = 8;
    localparam int RW   = 5;
    localparam int IW   = 3;
    localparam int SW   = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            alloc_valid;
    logic [RW-1:0]   alloc_rob_tag;
    logic [STQ-1:0]  alloc_store_mask;
    logic            alloc_ready;
    logic [IW-1:0]   alloc_index;
    logic            addr_valid;
    logic [IW-1:0]   addr_index;
    logic [XLEN-1:0] addr;
    logic            store_commit_valid;
    logic [SW-1:0]   store_commit_index;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic [IW-1:0]   mem_req_index;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [IW-1:0]   mem_resp_index;
    logic [XLEN-1:0] mem_resp_data;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob_tag;
    logic [XLEN-1:0] cdb_data;
    logic            commit_valid;
    logic            flush;
    logic            full;
    logic            empty;

    int vectors     = 0;
    int miscompares = 0;

    logic [RW+XLEN-1:0] exp_q [$];
    logic [RW+XLEN-1:0] cdb_exp;

    always #5 clk = ~clk;

    load_queue #(
        .XLEN(XLEN), .LDQ_BUF_SIZE(LDQ), .STQ_BUF_SIZE(STQ), .ROB_TAG_WIDTH(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag),
        .alloc_store_mask(alloc_store_mask), .alloc_ready(alloc_ready),
        .alloc_index(alloc_index),
        .addr_valid(addr_valid), .addr_index(addr_index), .addr(addr),
        .store_commit_valid(store_commit_valid), .store_commit_index(store_commit_index),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_index(mem_req_index), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_index(mem_resp_index),
        .mem_resp_data(mem_resp_data),
        .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .flush(flush),
        .full(full), .empty(empty)
    );

    // CDB scoreboard: every broadcast must match the oldest expected result
    always @(negedge clk) begin
        if (reset_n === 1'b1 && cdb_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cdb_unexpected: got tag=%0d data=%h, required no broadcast", cdb_rob_tag, cdb_data);
            end else begin
                cdb_exp = exp_q.pop_front();
                if ({cdb_rob_tag, cdb_data} !== cdb_exp) begin
                    miscompares++;
                    $display("FAIL cdb_result: got tag=%0d data=%h, required tag=%0d data=%h",
                             cdb_rob_tag, cdb_data, cdb_exp[RW+XLEN-1:XLEN], cdb_exp[XLEN-1:0]);
                end else begin
                    $display("cdb tag=%0d data=%h ok", cdb_rob_tag, cdb_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rob_tag = '0; alloc_store_mask = '0;
        addr_valid = 1'b0; addr_index = '0; addr = '0;
        store_commit_valid = 1'b0; store_commit_index = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_index = '0; mem_resp_data = '0;
        commit_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic do_alloc(input logic [RW-1:0] tag, input logic [STQ-1:0] mask);
        alloc_valid = 1'b1; alloc_rob_tag = tag; alloc_store_mask = mask;
        $display("alloc tag=%0d mask=%b at index %0d", tag, mask, alloc_index);
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic do_addr(input logic [IW-1:0] idx, input logic [XLEN-1:0] a);
        addr_valid = 1'b1; addr_index = idx; addr = a;
        step();
        addr_valid = 1'b0;
    endtask

    task automatic do_issue();
        mem_req_ready = 1'b1;
        $display("issue index=%0d addr=%h valid=%0b", mem_req_index, mem_req_addr, mem_req_valid);
        step();
        mem_req_ready = 1'b0;
    endtask

    task automatic do_resp(input logic [IW-1:0] idx, input logic [XLEN-1:0] d,
                           input logic [RW-1:0] tag, input bit expect_cdb);
        mem_resp_valid = 1'b1; mem_resp_index = idx; mem_resp_data = d;
        if (expect_cdb) exp_q.push_back({tag, d});
        step();
        mem_resp_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
    endtask

    task automatic do_store_commit(input logic [SW-1:0] idx);
        store_commit_valid = 1'b1; store_commit_index = idx;
        step();
        store_commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        $display("test_reset");
        alloc_valid = 1'b1; alloc_rob_tag = 5'd9;
        reset_n = 1'b0;
        step();
        step();
        alloc_valid = 1'b0;
        reset_n = 1'b1;
        vectors++; if (alloc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_alloc_ready: got %0b, required 1", alloc_ready); end
        vectors++; if (alloc_index !== 3'd0) begin miscompares++; $display("FAIL reset_alloc_index: got %0d, required 0", alloc_index); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %0b, required 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b, required 0", full); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %0b, required 0", mem_req_valid); end
        vectors++; if (mem_req_addr !== 32'd0) begin miscompares++; $display("FAIL reset_req_addr: got %h, required 0", mem_req_addr); end
        vectors++; if (mem_req_index !== 3'd0) begin miscompares++; $display("FAIL reset_req_index: got %0d, required 0", mem_req_index); end
        vectors++; if (cdb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cdb_valid: got %0b, required 0", cdb_valid); end
        vectors++; if (cdb_rob_tag !== 5'd0) begin miscompares++; $display("FAIL reset_cdb_tag: got %0d, required 0", cdb_rob_tag); end
        vectors++; if (cdb_data !== 32'd0) begin miscompares++; $display("FAIL reset_cdb_data: got %h, required 0", cdb_data); end
    endtask

    task automatic test_basic_load();
        $display("test_basic_load");
        do_alloc(5'd3, 8'b0);
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL basic_not_empty: got %0b, required 0", empty); end
        vectors++; if (alloc_index !== 3'd1) begin miscompares++; $display("FAIL basic_tail: got %0d, required 1", alloc_index); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL basic_no_req_before_addr: got %0b, required 0", mem_req_valid); end
        do_addr(3'd0, 32'h100);
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL basic_req_valid: got %0b, required 1", mem_req_valid); end
        vectors++; if (mem_req_addr !== 32'h100) begin miscompares++; $display("FAIL basic_req_addr: got %h, required 100", mem_req_addr); end
        vectors++; if (mem_req_index !== 3'd0) begin miscompares++; $display("FAIL basic_req_index: got %0d, required 0", mem_req_index); end
        do_issue();
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL basic_req_cleared: got %0b, required 0", mem_req_valid); end
        do_resp(3'd0, 32'hDEAD, 5'd3, 1'b1);
        vectors++; if (cdb_valid !== 1'b1) begin miscompares++; $display("FAIL basic_cdb_valid: got %0b, required 1", cdb_valid); end
        do_commit();
        vectors++; if (cdb_valid !== 1'b0) begin miscompares++; $display("FAIL basic_cdb_one_cycle: got %0b, required 0", cdb_valid); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty_after_commit: got %0b, required 1", empty); end
    endtask

    task automatic test_store_dependency();
        $display("test_store_dependency");
        do_alloc(5'd7, 8'b0000_0100);
        do_addr(3'd1, 32'h200);
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL dep_blocked: got %0b, required 0", mem_req_valid); end
        do_store_commit(3'd1);
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL dep_wrong_store: got %0b, required 0", mem_req_valid); end
        do_store_commit(3'd2);
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL dep_released: got %0b, required 1", mem_req_valid); end
        vectors++; if (mem_req_index !== 3'd1) begin miscompares++; $display("FAIL dep_index: got %0d, required 1", mem_req_index); end
        vectors++; if (mem_req_addr !== 32'h200) begin miscompares++; $display("FAIL dep_addr: got %h, required 200", mem_req_addr); end
        do_issue();
        do_resp(3'd1, 32'h1234, 5'd7, 1'b1);
        do_commit();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL dep_empty: got %0b, required 1", empty); end
    endtask

    task automatic test_oldest_first();
        $display("test_oldest_first");
        do_reset();
        do_alloc(5'd4, 8'b0000_0001);
        do_alloc(5'd5, 8'b0000_0001);
        do_addr(3'd1, 32'h310);
        do_addr(3'd0, 32'h300);
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL oldest_blocked: got %0b, required 0", mem_req_valid); end
        do_store_commit(3'd0);
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (mem_req_valid !== 1'b1 || mem_req_index !== 3'd0 || mem_req_addr !== 32'h300) begin
                miscompares++;
                $display("FAIL oldest_hold_%0d: got v=%0b idx=%0d addr=%h, required v=1 idx=0 addr=300", c, mem_req_valid, mem_req_index, mem_req_addr);
            end
            if (c < 3) step();
        end
        do_issue();
        vectors++; if (mem_req_index !== 3'd1 || mem_req_addr !== 32'h310) begin miscompares++; $display("FAIL oldest_second: got idx=%0d addr=%h, required idx=1 addr=310", mem_req_index, mem_req_addr); end
        do_issue();
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL oldest_drained: got %0b, required 0", mem_req_valid); end
        do_resp(3'd0, 32'h11, 5'd4, 1'b1);
        do_resp(3'd1, 32'h22, 5'd5, 1'b1);
        do_commit();
        do_commit();
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL oldest_empty: got %0b, required 1", empty); end
    endtask

    task automatic test_full_wrap();
        $display("test_full_wrap");
        do_reset();
        for (int i = 0; i < 7; i++) do_alloc(5'(10 + i), 8'b0);
        vectors++; if (alloc_index !== 3'd7 || full !== 1'b0) begin miscompares++; $display("FAIL wrap_seven: got idx=%0d full=%0b, required idx=7 full=0", alloc_index, full); end
        do_addr(3'd0, 32'h400);
        do_issue();
        do_resp(3'd0, 32'hA0, 5'd10, 1'b1);
        alloc_valid = 1'b1; alloc_rob_tag = 5'd17; alloc_store_mask = '0; commit_valid = 1'b1;
        step();
        alloc_valid = 1'b0; commit_valid = 1'b0;
        vectors++; if (alloc_index !== 3'd0) begin miscompares++; $display("FAIL wrap_tail: got %0d, required 0", alloc_index); end
        vectors++; if (full !== 1'b0 || empty !== 1'b0) begin miscompares++; $display("FAIL wrap_count7: got full=%0b empty=%0b, required 0 0", full, empty); end
        do_alloc(5'd18, 8'b0);
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %0b, required 1", full); end
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %0b, required 0", alloc_ready); end
        vectors++; if (alloc_index !== 3'd1) begin miscompares++; $display("FAIL full_tail: got %0d, required 1", alloc_index); end
        do_alloc(5'd19, 8'b0);
        vectors++; if (alloc_index !== 3'd1 || full !== 1'b1) begin miscompares++; $display("FAIL full_ignored: got idx=%0d full=%0b, required idx=1 full=1", alloc_index, full); end
    endtask

    task automatic test_flush();
        $display("test_flush");
        do_addr(3'd1, 32'h500);
        do_addr(3'd2, 32'h510);
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_index !== 3'd1) begin miscompares++; $display("FAIL flush_pre_req: got v=%0b idx=%0d, required v=1 idx=1", mem_req_valid, mem_req_index); end
        do_issue();
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL flush_empty: got empty=%0b full=%0b, required 1 0", empty, full); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL flush_req: got %0b, required 0", mem_req_valid); end
        vectors++; if (alloc_index !== 3'd1 || alloc_ready !== 1'b1) begin miscompares++; $display("FAIL flush_tail: got idx=%0d ready=%0b, required idx=1 ready=1", alloc_index, alloc_ready); end
        do_resp(3'd1, 32'hBAD, 5'd0, 1'b0);
        vectors++; if (cdb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_late_resp: got cdb_valid=%0b, required 0", cdb_valid); end
        step();
    endtask

    task automatic test_commit_guard();
        $display("test_commit_guard");
        do_alloc(5'd20, 8'b0);
        do_commit();
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL guard_not_ready: got empty=%0b, required 0", empty); end
        do_addr(3'd1, 32'h600);
        vectors++; if (mem_req_index !== 3'd1 || mem_req_addr !== 32'h600) begin miscompares++; $display("FAIL guard_req: got idx=%0d addr=%h, required idx=1 addr=600", mem_req_index, mem_req_addr); end
        do_issue();
        do_commit();
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL guard_executed_only: got empty=%0b, required 0", empty); end
        do_resp(3'd1, 32'h77, 5'd20, 1'b1);
        do_commit();
        vectors++; if (empty !== 1'b1 || alloc_index !== 3'd2) begin miscompares++; $display("FAIL guard_freed: got empty=%0b idx=%0d, required 1 2", empty, alloc_index); end
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b1;
        test_reset();
        test_basic_load();
        test_store_dependency();
        test_oldest_first();
        test_full_wrap();
        test_flush();
        test_commit_guard();
        step();
        step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cdb_missing: got %0d outstanding broadcasts, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
